// File: rtl/joybus_device_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : joybus_device_responder
// Purpose  : Device-side (controller-end) joybus responder. Emulates a single
//            N64 controller on one open-drain joy line: decodes the host
//            command byte, then transmits the matching reply frame.
//            The pad is expected to be wired as  joy = joy_oe ? 1'b0 : 1'bz.
// Ports    : clk          system clock
//            reset        synchronous active-high reset
//            joy_in       raw joy line level (asynchronous)
//            joy_oe       1 = pull the line low, 0 = release
//            buttons      {A,B,Z,St,dU,dD,dL,dR,rst,0,L,R,cU,cD,cL,cR}
//            stick_x/y    signed analog axes
//            pak_present  accessory inserted
//            cmd_valid    one-cycle pulse when a supported command is accepted
//            cmd_byte     last accepted command
//            busy         high from first command falling edge to reply end
//            rx_error     one-cycle pulse on a framing abort
// Revision : 1.0  initial release
// ============================================================================
module joybus_device_responder #(
    parameter int US_TICKS  = 50,
    parameter int TURN_US   = 2,
    parameter int IDLE_US   = 5,
    parameter int MAXLOW_US = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        joy_in,
    output logic        joy_oe,
    input  logic [15:0] buttons,
    input  logic [7:0]  stick_x,
    input  logic [7:0]  stick_y,
    input  logic        pak_present,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        busy,
    output logic        rx_error
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_ST_IDLE    = 4'd0;
    localparam logic [3:0] c_ST_RX_LOW  = 4'd1;
    localparam logic [3:0] c_ST_RX_HIGH = 4'd2;
    localparam logic [3:0] c_ST_RX_STOP = 4'd3;
    localparam logic [3:0] c_ST_TURN    = 4'd4;
    localparam logic [3:0] c_ST_TX_LOW  = 4'd5;
    localparam logic [3:0] c_ST_TX_HIGH = 4'd6;
    localparam logic [3:0] c_ST_TX_STOP = 4'd7;
    localparam logic [3:0] c_ST_ABORT   = 4'd8;

    // ------------------------------------------------------------------------
    // Timing constants
    // ------------------------------------------------------------------------
    localparam int              c_TW         = (US_TICKS > 1) ? $clog2(US_TICKS) : 1;
    localparam logic [c_TW-1:0] c_TICK_LAST  = c_TW'(US_TICKS - 1);
    localparam logic [15:0]     c_BIT1_MAX   = 16'(2 * US_TICKS);
    localparam logic [15:0]     c_MAXLOW     = 16'(MAXLOW_US * US_TICKS);
    localparam logic [15:0]     c_IDLE_W     = 16'(IDLE_US * US_TICKS);
    localparam logic [7:0]      c_TURN_LAST  = 8'(TURN_US - 1);
    // Microsecond indices (elapsed-1) used for reply bit phases
    localparam logic [7:0]      c_US_IDX_1   = 8'd0;
    localparam logic [7:0]      c_US_IDX_2   = 8'd1;
    localparam logic [7:0]      c_US_IDX_3   = 8'd2;
    localparam logic [15:0]     c_SAT        = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic            r_sync1, r_sync2, r_sync3;
    logic            w_line, w_fall, w_rise;

    logic [15:0]     r_low_cnt;
    logic [15:0]     r_high_cnt;

    logic [c_TW-1:0] r_tick;
    logic [7:0]      r_us_cnt;
    logic            w_tick_last;
    logic            w_state_chg;

    logic [3:0]      r_state;
    logic [3:0]      w_state_next;

    logic [3:0]      r_bitcnt;
    logic [7:0]      r_rx_sr;
    logic            w_rx_bit;
    logic            w_rx_supported;

    logic [31:0]     r_tx_sr;
    logic [5:0]      r_tx_left;
    logic            w_tx_bit;

    logic            w_rx_start;
    logic            w_rx_shift;
    logic            w_accept;
    logic            w_frame_err;
    logic            w_tx_shift;

    logic            r_joy_oe;
    logic            r_busy;
    logic            r_cmd_valid;
    logic [7:0]      r_cmd_byte;
    logic            r_rx_error;

    // ------------------------------------------------------------------------
    // Input synchroniser and edge detect. Reset to the idle (high) level so a
    // reset release never looks like a falling edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= joy_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_line = r_sync2;
    assign w_fall = r_sync3 & ~r_sync2;
    assign w_rise = ~r_sync3 & r_sync2;

    // ------------------------------------------------------------------------
    // Level width counters. On the cycle a rising edge is seen, r_low_cnt
    // still holds the exact number of low cycles of the pulse just ended.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_low_cnt  <= 16'd0;
            r_high_cnt <= 16'd0;
        end else if (w_line) begin
            r_low_cnt <= 16'd0;
            if (r_high_cnt != c_SAT) begin
                r_high_cnt <= r_high_cnt + 16'd1;
            end
        end else begin
            r_high_cnt <= 16'd0;
            if (r_low_cnt != c_SAT) begin
                r_low_cnt <= r_low_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Microsecond timebase, restarted on every state entry so each state's
    // duration is counted from its first cycle.
    // ------------------------------------------------------------------------
    assign w_state_chg = (w_state_next != r_state);
    assign w_tick_last = (r_tick == c_TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset || w_state_chg) begin
            r_tick   <= '0;
            r_us_cnt <= 8'd0;
        end else if (w_tick_last) begin
            r_tick <= '0;
            if (r_us_cnt != 8'hFF) begin
                r_us_cnt <= r_us_cnt + 8'd1;
            end
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------------
    assign w_rx_bit       = (r_low_cnt < c_BIT1_MAX);
    assign w_rx_supported = (r_rx_sr == 8'h00) || (r_rx_sr == 8'h01) ||
                            (r_rx_sr == 8'hFF);
    assign w_tx_bit       = r_tx_sr[31];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_rx_start   = 1'b0;
        w_rx_shift   = 1'b0;
        w_accept     = 1'b0;
        w_frame_err  = 1'b0;
        w_tx_shift   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_fall) begin
                    w_state_next = c_ST_RX_LOW;
                    w_rx_start   = 1'b1;
                end
            end

            c_ST_RX_LOW: begin
                if (w_rise) begin
                    w_state_next = c_ST_RX_HIGH;
                    w_rx_shift   = 1'b1;
                end else if (r_low_cnt > c_MAXLOW) begin
                    w_state_next = c_ST_ABORT;
                    w_frame_err  = 1'b1;
                end
            end

            c_ST_RX_HIGH: begin
                if (w_fall) begin
                    w_state_next = (r_bitcnt == 4'd8) ? c_ST_RX_STOP : c_ST_RX_LOW;
                end else if (r_high_cnt > c_IDLE_W) begin
                    w_state_next = c_ST_ABORT;
                    w_frame_err  = 1'b1;
                end
            end

            c_ST_RX_STOP: begin
                if (w_rise) begin
                    // Unsupported commands are dropped silently: no error.
                    if (w_rx_supported) begin
                        w_state_next = c_ST_TURN;
                        w_accept     = 1'b1;
                    end else begin
                        w_state_next = c_ST_ABORT;
                    end
                end else if (r_low_cnt > c_MAXLOW) begin
                    w_state_next = c_ST_ABORT;
                    w_frame_err  = 1'b1;
                end
            end

            c_ST_TURN: begin
                if (w_tick_last && (r_us_cnt == c_TURN_LAST)) begin
                    w_state_next = c_ST_TX_LOW;
                end
            end

            // The line is not observed while transmitting: our own echo and
            // any host drive are both ignored.
            c_ST_TX_LOW: begin
                if (w_tick_last &&
                    (r_us_cnt == (w_tx_bit ? c_US_IDX_1 : c_US_IDX_3))) begin
                    w_state_next = c_ST_TX_HIGH;
                end
            end

            c_ST_TX_HIGH: begin
                if (w_tick_last &&
                    (r_us_cnt == (w_tx_bit ? c_US_IDX_3 : c_US_IDX_1))) begin
                    w_tx_shift   = 1'b1;
                    w_state_next = (r_tx_left == 6'd1) ? c_ST_TX_STOP : c_ST_TX_LOW;
                end
            end

            c_ST_TX_STOP: begin
                if (w_tick_last && (r_us_cnt == c_US_IDX_2)) begin
                    w_state_next = c_ST_IDLE;
                end
            end

            c_ST_ABORT: begin
                if (w_line && (r_high_cnt >= c_IDLE_W)) begin
                    w_state_next = c_ST_IDLE;
                end
            end

            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and datapath. joy_oe and busy are registered decodes of
    // the next state so the pad driver never sees decode glitches.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_joy_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_byte  <= 8'h00;
            r_rx_error  <= 1'b0;
            r_bitcnt    <= 4'd0;
            r_rx_sr     <= 8'h00;
            r_tx_sr     <= 32'h0;
            r_tx_left   <= 6'd0;
        end else begin
            r_state     <= w_state_next;
            r_joy_oe    <= (w_state_next == c_ST_TX_LOW) ||
                           (w_state_next == c_ST_TX_STOP);
            r_busy      <= (w_state_next != c_ST_IDLE);
            r_cmd_valid <= w_accept;
            r_rx_error  <= w_frame_err;

            if (w_rx_start) begin
                r_bitcnt <= 4'd0;
                r_rx_sr  <= 8'h00;
            end else if (w_rx_shift) begin
                r_bitcnt <= r_bitcnt + 4'd1;
                r_rx_sr  <= {r_rx_sr[6:0], w_rx_bit};
            end

            // Inputs are captured once here; later changes cannot disturb
            // the reply already in flight.
            if (w_accept) begin
                r_cmd_byte <= r_rx_sr;
                if (r_rx_sr == 8'h01) begin
                    r_tx_sr   <= {buttons, stick_x, stick_y};
                    r_tx_left <= 6'd32;
                end else begin
                    r_tx_sr   <= {8'h05, 8'h00,
                                  (pak_present ? 8'h01 : 8'h02), 8'h00};
                    r_tx_left <= 6'd24;
                end
            end else if (w_tx_shift) begin
                r_tx_sr   <= {r_tx_sr[30:0], 1'b0};
                r_tx_left <= r_tx_left - 6'd1;
            end
        end
    end

    assign joy_oe    = r_joy_oe;
    assign busy      = r_busy;
    assign cmd_valid = r_cmd_valid;
    assign cmd_byte  = r_cmd_byte;
    assign rx_error  = r_rx_error;

endmodule
`default_nettype wire

// File: tb/tb_joybus_device_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_joybus_device_responder
// Purpose  : Self-checking bench for joybus_device_responder. Plays the host
//            side of the open-drain line, decodes the reply pulses and
//            compares against hand-computed frames.
// Revision : 1.0  initial release
// ============================================================================
module tb_joybus_device_responder;

    logic        clk;
    logic        reset;
    logic        host_low;
    logic        joy_in;
    logic        joy_oe;
    logic [15:0] buttons;
    logic [7:0]  stick_x;
    logic [7:0]  stick_y;
    logic        pak_present;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        busy;
    logic        rx_error;

    int n_vec = 0;
    int n_bad = 0;
    int n_cv  = 0;
    int n_err = 0;
    int n_oe  = 0;

    // Wired-AND open-drain line: either side may pull it low.
    assign joy_in = ~(host_low | joy_oe);

    joybus_device_responder dut (
        .clk         (clk),
        .reset       (reset),
        .joy_in      (joy_in),
        .joy_oe      (joy_oe),
        .buttons     (buttons),
        .stick_x     (stick_x),
        .stick_y     (stick_y),
        .pak_present (pak_present),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .busy        (busy),
        .rx_error    (rx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitors, sampled on the opposite edge.
    always @(negedge clk) begin
        if (cmd_valid) n_cv  <= n_cv + 1;
        if (rx_error)  n_err <= n_err + 1;
        if (joy_oe)    n_oe  <= n_oe + 1;
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] btn;
        logic [7:0]  sx;
        logic [7:0]  sy;
        logic        pak;
        int          nbits;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [5];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Host bit: '1' = 1us low / 3us high, '0' = 3us low / 1us high.
    task automatic host_bit(input logic b);
        host_low = 1'b1;
        cyc(b ? 50 : 150);
        host_low = 1'b0;
        cyc(b ? 150 : 50);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) host_bit(v[i]);
    endtask

    // Stop bit: 1us low, then the line is released (returns right at release).
    task automatic send_stop();
        host_low = 1'b1;
        cyc(50);
        host_low = 1'b0;
    endtask

    // Decodes the reply from joy_oe pulse widths: 50 = '1', 150 = '0',
    // 100 = stop. Each data bit must span exactly 200 cycles. Inputs are
    // scrambled once the reply starts to prove the snapshot is held.
    task automatic capture(output logic [31:0] data, output int nbits,
                           output int turn, output int stop_w, output int bad);
        int  w;
        int  g;
        bit  done;
        data = 32'h0; nbits = 0; turn = 0; stop_w = 0; bad = 0; done = 1'b0;
        while (!joy_oe && turn < 400) begin
            cyc(1);
            turn++;
        end
        if (!joy_oe) begin
            bad = 1;
            return;
        end
        buttons     = ~buttons;
        stick_x     = ~stick_x;
        stick_y     = ~stick_y;
        pak_present = ~pak_present;
        while (!done) begin
            w = 0;
            while (joy_oe && w < 400) begin
                cyc(1);
                w++;
            end
            if (w == 100) begin
                stop_w = w;
                done   = 1'b1;
            end else if (w == 50 || w == 150) begin
                data = {data[30:0], (w == 50)};
                nbits++;
                g = 0;
                while (!joy_oe && g < 400) begin
                    cyc(1);
                    g++;
                end
                if (w + g != 200) bad++;
                if (g >= 400 || nbits > 40) begin
                    bad++;
                    done = 1'b1;
                end
            end else begin
                bad++;
                stop_w = w;
                done   = 1'b1;
            end
        end
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        logic [31:0] d;
        int nb, turn, sw, bad, cv0, er0;
        buttons     = v.btn;
        stick_x     = v.sx;
        stick_y     = v.sy;
        pak_present = v.pak;
        cv0 = n_cv;
        er0 = n_err;
        send_byte(v.cmd);
        send_stop();
        capture(d, nb, turn, sw, bad);
        check({tag, ".cmd_valid_pulses"}, n_cv - cv0, 1);
        check({tag, ".cmd_byte"}, cmd_byte, v.cmd);
        check({tag, ".nbits"}, nb, v.nbits);
        check({tag, ".data"}, d, v.data);
        // Includes the 2-3 cycle input synchroniser latency.
        check_rng({tag, ".turnaround"}, turn, 100, 104);
        check({tag, ".stop_len"}, sw, 100);
        check({tag, ".bit_timing_errs"}, bad, 0);
        check({tag, ".no_rx_error"}, n_err - er0, 0);
        cyc(5);
        check({tag, ".busy_after"}, busy, 0);
        cyc(20);
    endtask

    initial begin
        logic [31:0] d;
        int cv0, er0, oe0, k, rises;
        logic prev;

        vecs[0] = '{8'h01, 16'h9020, 8'h7F, 8'h81, 1'b0, 32, 32'h9020_7F81};
        vecs[1] = '{8'h00, 16'h0000, 8'h00, 8'h00, 1'b1, 24, 32'h0005_0001};
        vecs[2] = '{8'hFF, 16'h0000, 8'h00, 8'h00, 1'b0, 24, 32'h0005_0002};
        vecs[3] = '{8'h01, 16'hFFFF, 8'h00, 8'hFF, 1'b1, 32, 32'hFFFF_00FF};
        vecs[4] = '{8'h00, 16'h1234, 8'h55, 8'hAA, 1'b0, 24, 32'h0005_0002};

        reset = 1'b1; host_low = 1'b0;
        buttons = 16'h0; stick_x = 8'h0; stick_y = 8'h0; pak_present = 1'b0;
        cyc(5);
        reset = 1'b0;
        cyc(3);
        check("reset_outputs", {joy_oe, cmd_valid, cmd_byte, busy, rx_error}, 12'h000);
        cyc(20);

        // Main table
        for (int i = 0; i < 5; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

        // Unsupported command: silently ignored
        cv0 = n_cv; er0 = n_err; oe0 = n_oe;
        send_byte(8'h02);
        send_stop();
        check("unsup.busy_high", busy, 1);
        k = 0;
        while (busy && k < 600) begin
            cyc(1);
            k++;
        end
        check_rng("unsup.busy_fall", k, 250, 255);
        check("unsup.no_cmd_valid", n_cv - cv0, 0);
        check("unsup.no_rx_error", n_err - er0, 0);
        check("unsup.no_tx", n_oe - oe0, 0);
        check("unsup.cmd_byte_kept", cmd_byte, 8'h00);
        cyc(20);

        // Partial frame: 5 bits then the line stays high
        er0 = n_err; oe0 = n_oe;
        host_bit(1'b1); host_bit(1'b0); host_bit(1'b1); host_bit(1'b0);
        host_low = 1'b1;
        cyc(50);
        host_low = 1'b0;
        k = 0;
        while (!rx_error && k < 600) begin
            cyc(1);
            k++;
        end
        check_rng("partial.rx_error_time", k, 250, 256);
        cyc(300);
        check("partial.rx_error_once", n_err - er0, 1);
        check("partial.busy_low", busy, 0);
        check("partial.no_tx", n_oe - oe0, 0);
        run_cmd(vecs[0], "after_partial");

        // Over-long low pulse
        cv0 = n_cv; er0 = n_err; oe0 = n_oe;
        host_low = 1'b1;
        cyc(250);
        host_low = 1'b0;
        check("longlow.rx_error", n_err - er0, 1);
        k = 0;
        while (busy && k < 600) begin
            cyc(1);
            k++;
        end
        check_rng("longlow.busy_fall", k, 250, 255);
        check("longlow.no_tx", n_oe - oe0, 0);
        check("longlow.no_cmd_valid", n_cv - cv0, 0);
        cyc(20);

        // Reset during bit 10 of a 0x01 reply (bit 10 is a '1': 50-cycle low)
        buttons = 16'h9020; stick_x = 8'h7F; stick_y = 8'h81; pak_present = 1'b0;
        send_byte(8'h01);
        send_stop();
        rises = 0; prev = joy_oe; k = 0;
        while (rises < 11 && k < 6000) begin
            cyc(1);
            k++;
            if (joy_oe && !prev) rises++;
            prev = joy_oe;
        end
        check("midrst.reached_bit10", rises, 11);
        cyc(20);
        check("midrst.oe_before", joy_oe, 1);
        reset = 1'b1;
        cyc(1);
        check("midrst.oe_released", joy_oe, 0);
        check("midrst.busy_cleared", busy, 0);
        reset = 1'b0;
        cyc(300);
        run_cmd(vecs[1], "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
